// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, reset PC,
// halt opcode and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [5:0]  DEF_HALT_OPCODE = 6'b111111;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StIssue = 3'd3,
        StHalt  = 3'd4
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] val);
        return (val == {WORD_W{1'b1}}) ? val : val + 1'b1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Architectural PC register: loads a word-aligned copy of its input when
// enabled, returns to the reset PC on reset.
module instr_fetch_unit_pc_register
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_d,
    output logic [WORD_W-1:0] o_q
);

    logic [WORD_W-1:0] r_pc;

    // Hold the PC; low two bits are always forced to zero on load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_d & ~{{(WORD_W-2){1'b0}}, 2'b11};
        end
    end

    assign o_q = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests the word at pc, latches it, presents it to
// decode/execute and moves to the resolved next_pc once execution retires it.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [5:0]        HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_imem_req,
    output logic [WORD_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic              i_imem_rvalid,
    input  logic [WORD_W-1:0] i_imem_rdata,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_instr,
    output logic              o_instr_valid,
    input  logic [WORD_W-1:0] i_next_pc,
    input  logic              i_exec_done,
    output logic              o_halted,
    output logic              o_align_err,
    output logic [WORD_W-1:0] o_fetch_count
);

    fetch_state_e      r_state;
    logic              r_imem_req;
    logic [WORD_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_halted;
    logic              r_align_err;
    logic [WORD_W-1:0] r_fetch_count;

    logic              w_pc_load;
    logic [WORD_W-1:0] w_pc;

    // Retirement in ISSUE is the only event that moves the PC
    assign w_pc_load = (r_state == StIssue) && i_exec_done;

    instr_fetch_unit_pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_pc_load),
        .i_d    (i_next_pc),
        .o_q    (w_pc)
    );

    // Fetch FSM with registered request/valid/halt outputs, instr latch and counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_imem_req    <= 1'b0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_align_err   <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state    <= StReq;
                        r_imem_req <= 1'b1;
                    end
                end
                StReq: begin
                    if (i_imem_ready) begin
                        r_state    <= StWait;
                        r_imem_req <= 1'b0;
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        r_instr       <= i_imem_rdata;
                        r_fetch_count <= sat_inc(r_fetch_count);
                        if (i_imem_rdata[31:26] == HALT_OPCODE) begin
                            r_state  <= StHalt;
                            r_halted <= 1'b1;
                        end else begin
                            r_state       <= StIssue;
                            r_instr_valid <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (i_exec_done) begin
                        r_state       <= StReq;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_align_err   <= r_align_err | (|i_next_pc[1:0]);
                    end
                end
                StHalt: begin
                    // Terminal until reset
                    r_state <= StHalt;
                end
                default: begin
                    r_state       <= StIdle;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = w_pc;
    assign o_pc          = w_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = r_halted;
    assign o_align_err   = r_align_err;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of fetch/retire vectors plus
// hand-written halt and reset-during-wait sequences, with a scoreboard queue.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic [31:0] i_next_pc;
    logic        i_exec_done;
    logic        o_halted;
    logic        o_align_err;
    logic [31:0] o_fetch_count;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .i_next_pc     (i_next_pc),
        .i_exec_done   (i_exec_done),
        .o_halted      (o_halted),
        .o_align_err   (o_align_err),
        .o_fetch_count (o_fetch_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic [31:0] next_pc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_align;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!o_imem_req && k < 8) begin
            step();
            k++;
        end
        chk({tag, " req"}, {31'd0, o_imem_req}, 32'd1);
    endtask

    // Drive one fetch from REQ through to ISSUE and score the presented instruction
    task automatic fetch(input logic [31:0] rdata, input int rdy_dly, input int rv_dly,
                         input string tag);
        exp_t e;
        int   k;
        wait_req(tag);
        chk({tag, " addr"}, o_imem_addr, m_pc);
        for (int j = 0; j < rdy_dly; j++) begin
            // exec_done and start must be ignored while the request is pending
            i_exec_done = 1'b1;
            i_next_pc   = 32'h0000_0888;
            i_start     = 1'b1;
            step();
            chk({tag, " stall req"}, {31'd0, o_imem_req}, 32'd1);
            chk({tag, " stall addr"}, o_imem_addr, m_pc);
        end
        i_exec_done  = 1'b0;
        i_start      = 1'b0;
        i_imem_ready = 1'b1;
        step();
        i_imem_ready = 1'b0;
        chk({tag, " req drop"}, {31'd0, o_imem_req}, 32'd0);
        for (int j = 0; j < rv_dly; j++) begin
            step();
            chk({tag, " early valid"}, {31'd0, o_instr_valid}, 32'd0);
        end
        if (m_count != 32'hFFFF_FFFF) m_count++;
        e.pc    = m_pc;
        e.instr = rdata;
        e.count = m_count;
        sb.push_back(e);
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = rdata;
        step();
        i_imem_rvalid = 1'b0;
        k = 0;
        while (!o_instr_valid && k < 8) begin
            step();
            k++;
        end
        chk({tag, " valid"}, {31'd0, o_instr_valid}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " pc"}, o_pc, e.pc);
            chk({tag, " instr"}, o_instr, e.instr);
            chk({tag, " count"}, o_fetch_count, e.count);
        end
    endtask

    // Retire the presented instruction and check the next request
    task automatic retire(input logic [31:0] npc, input string tag);
        i_exec_done = 1'b1;
        i_next_pc   = npc;
        step();
        i_exec_done = 1'b0;
        m_pc    = {npc[31:2], 2'b00};
        m_align = m_align | (|npc[1:0]);
        chk({tag, " valid drop"}, {31'd0, o_instr_valid}, 32'd0);
        chk({tag, " next req"}, {31'd0, o_imem_req}, 32'd1);
        chk({tag, " next addr"}, o_imem_addr, m_pc);
        chk({tag, " align"}, {31'd0, o_align_err}, {31'd0, m_align});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc"}, o_pc, 32'h0);
        chk({tag, " instr"}, o_instr, 32'h0);
        chk({tag, " req"}, {31'd0, o_imem_req}, 32'd0);
        chk({tag, " valid"}, {31'd0, o_instr_valid}, 32'd0);
        chk({tag, " halted"}, {31'd0, o_halted}, 32'd0);
        chk({tag, " align"}, {31'd0, o_align_err}, 32'd0);
        chk({tag, " count"}, o_fetch_count, 32'h0);
    endtask

    initial begin
        i_rst         = 1'b1;
        i_start       = 1'b0;
        i_imem_ready  = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_next_pc     = 32'h0;
        i_exec_done   = 1'b0;
        m_pc          = 32'h0;
        m_count       = 32'h0;
        m_align       = 1'b0;

        vecs[0] = '{32'h2000_0001, 0, 0, 32'h0000_0040};
        vecs[1] = '{32'h1234_5678, 0, 0, 32'h0000_0004};
        vecs[2] = '{32'hABCD_0000, 5, 3, 32'h0000_0046};
        vecs[3] = '{32'h0000_0013, 1, 0, 32'h0000_0100};
        vecs[4] = '{32'h8000_0000, 0, 1, 32'hFFFF_FFFC};
        vecs[5] = '{32'h1111_1111, 0, 0, 32'h0000_0000};

        step();
        step();
        chk_reset("reset");
        i_rst = 1'b0;
        step();
        chk("idle no start", {31'd0, o_imem_req}, 32'd0);

        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("start latency", {31'd0, o_imem_req}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            fetch(vecs[i].rdata, vecs[i].rdy_dly, vecs[i].rv_dly, tag);
            if (i == 1) begin
                i_start = 1'b1;
                step();
                i_start = 1'b0;
                chk("start in issue valid", {31'd0, o_instr_valid}, 32'd1);
                chk("start in issue req", {31'd0, o_imem_req}, 32'd0);
            end
            if (i == 2) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = 32'hDEAD_BEEF;
                step();
                i_imem_rvalid = 1'b0;
                chk("stray rvalid instr", o_instr, vecs[i].rdata);
                chk("stray rvalid valid", {31'd0, o_instr_valid}, 32'd1);
                chk("stray rvalid count", o_fetch_count, m_count);
            end
            retire(vecs[i].next_pc, tag);
        end

        // Halt opcode fetch
        wait_req("halt");
        chk("halt addr", o_imem_addr, m_pc);
        i_imem_ready = 1'b1;
        step();
        i_imem_ready  = 1'b0;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'hFC00_0000;
        step();
        i_imem_rvalid = 1'b0;
        m_count++;
        chk("halt halted", {31'd0, o_halted}, 32'd1);
        chk("halt valid", {31'd0, o_instr_valid}, 32'd0);
        chk("halt req", {31'd0, o_imem_req}, 32'd0);
        chk("halt instr", o_instr, 32'hFC00_0000);
        chk("halt count", o_fetch_count, m_count);
        for (int j = 0; j < 3; j++) begin
            i_start       = 1'b1;
            i_exec_done   = 1'b1;
            i_next_pc     = 32'h0000_0200;
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = 32'h2000_0001;
            step();
        end
        i_start       = 1'b0;
        i_exec_done   = 1'b0;
        i_imem_rvalid = 1'b0;
        chk("halted sticky", {31'd0, o_halted}, 32'd1);
        chk("halted req", {31'd0, o_imem_req}, 32'd0);
        chk("halted valid", {31'd0, o_instr_valid}, 32'd0);
        chk("halted pc", o_pc, m_pc);
        chk("halted count", o_fetch_count, m_count);

        // Asynchronous reset out of HALT, checked before the next edge
        i_rst = 1'b1;
        #1;
        chk("rst halt pc", o_pc, 32'h0);
        chk("rst halt halted", {31'd0, o_halted}, 32'd0);
        step();
        i_rst   = 1'b0;
        m_pc    = 32'h0;
        m_count = 32'h0;
        m_align = 1'b0;
        chk_reset("post halt rst");

        // Reset mid-WAIT coinciding with a response
        i_start = 1'b1;
        step();
        i_start      = 1'b0;
        i_imem_ready = 1'b1;
        step();
        i_imem_ready  = 1'b0;
        i_rst         = 1'b1;
        i_imem_rvalid = 1'b1;
        i_imem_rdata  = 32'h2000_0001;
        step();
        i_imem_rvalid = 1'b0;
        chk_reset("rst in wait");
        i_rst = 1'b0;
        step();
        step();
        chk("idle after rst req", {31'd0, o_imem_req}, 32'd0);
        chk("idle after rst count", o_fetch_count, 32'h0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("restart req", {31'd0, o_imem_req}, 32'd1);
        chk("restart addr", o_imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
